// File: rtl/fsm_step_sequencer.sv
// Step pulse sequencer: debounced button and auto timer arbitration.
// Ports: clk, rst_n, btn_n, sw_in[1:0], auto_en -> step, sw_out[1:0], src, busy, drop_cnt[7:0].
module fsm_step_sequencer #(
    parameter int DEB_CYCLES  = 16,
    parameter int AUTO_PERIOD = 100,
    parameter int GAP_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n,
    input  logic [1:0] sw_in,
    input  logic       auto_en,
    output logic       step,
    output logic [1:0] sw_out,
    output logic       src,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
    localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
    localparam bit            HAS_GAP  = (GAP_CYCLES > 0);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_GAP  = 1'b1;

    logic          btn_s1;
    logic          btn_s2;
    logic [1:0]    sw_s1;
    logic [1:0]    sw_s2;
    logic [DW-1:0] deb_cnt;
    logic          deb_lvl;
    logic          deb_lvl_d;
    logic          press;
    logic [AW-1:0] auto_cnt;
    logic          wrap;
    logic          man_pend;
    logic          auto_pend;
    logic          auto_req;
    logic          any_req;
    logic          win_auto;
    logic          gnt_man;
    logic          gnt_auto;
    logic          drop_man;
    logic          drop_auto;
    logic [8:0]    drop_sum;
    logic [0:0]    state;
    logic [GW-1:0] gap_cnt;
    logic          last_src;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
            sw_s1  <= 2'b00;
            sw_s2  <= 2'b00;
        end else begin
            btn_s1 <= btn_n;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_in;
            sw_s2  <= sw_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_cnt   <= '0;
            deb_lvl   <= 1'b1;
            deb_lvl_d <= 1'b1;
        end else begin
            deb_lvl_d <= deb_lvl;
            if (btn_s2 != deb_lvl) begin
                if (deb_cnt == DEB_MAX) begin
                    deb_lvl <= btn_s2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Press = debounced level just fell; release is ignored.
    assign press = deb_lvl_d & ~deb_lvl;

    assign wrap = auto_en & (auto_cnt == AUTO_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n || !auto_en) begin
            auto_cnt <= '0;
        end else if (wrap) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + AW'(1);
        end
    end

    // A stale auto request is masked as soon as the timer is disabled.
    assign auto_req = auto_pend & auto_en;
    assign any_req  = man_pend | auto_req;

    always_comb begin
        win_auto = 1'b0;
        unique case ({man_pend, auto_req})
            2'b01:   win_auto = 1'b1;
            2'b11:   win_auto = ~last_src;
            default: win_auto = 1'b0;
        endcase
    end

    assign gnt_man  = (state == S_IDLE) & any_req & ~win_auto;
    assign gnt_auto = (state == S_IDLE) & any_req & win_auto;

    // A new request arriving with the grant is kept, not dropped.
    assign drop_man  = press & man_pend & ~gnt_man;
    assign drop_auto = wrap & auto_pend & ~gnt_auto;
    assign drop_sum  = {1'b0, drop_cnt} + {8'd0, drop_man} + {8'd0, drop_auto};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            man_pend <= 1'b0;
        end else if (press) begin
            man_pend <= 1'b1;
        end else if (gnt_man) begin
            man_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !auto_en) begin
            auto_pend <= 1'b0;
        end else if (wrap) begin
            auto_pend <= 1'b1;
        end else if (gnt_auto) begin
            auto_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else begin
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            gap_cnt  <= '0;
            step     <= 1'b0;
            busy     <= 1'b0;
            sw_out   <= 2'b00;
            src      <= 1'b0;
            last_src <= 1'b1;
        end else begin
            step <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        step     <= 1'b1;
                        sw_out   <= sw_s2;
                        src      <= win_auto;
                        last_src <= win_auto;
                        gap_cnt  <= GAP_LOAD;
                        if (HAS_GAP) begin
                            state <= S_GAP;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fsm_step_sequencer.md
Name: fsm_step_sequencer

Overview:
- Produces the single-cycle step pulses that advance the board's colour-state Mealy FSM.
- Arbitrates two step requesters: a debounced manual push-button and a periodic auto-step timer.
- Enforces a minimum spacing between steps.
- Each grant captures a stable switch snapshot that the FSM consumes with the step.

Parameters:
DEB_CYCLES, 16, consecutive stable cycles needed to accept a button level change (board build: 1250000)
AUTO_PERIOD, 100, cycles between auto-step requests while auto_en=1 (board build: 125000000)
GAP_CYCLES, 4, busy cycles after each step; minimum step-to-step spacing is GAP_CYCLES+1

Ports:
clk  in  1  system clock (CLOCK_125_p domain)
rst_n  in  1  synchronous active-low reset
btn_n  in  1  raw asynchronous push-button, active low (KEY)
sw_in  in  2  raw asynchronous switches (SW[1:0])
auto_en  in  1  synchronous enable for the auto-step timer
step  out  1  one-cycle step pulse to the FSM
sw_out  out  2  switch snapshot registered with the last step, held until the next step
src  out  1  source of the last step: 0 = manual, 1 = auto
busy  out  1  high during the gap period
drop_cnt  out  8  saturating count of dropped requests

Behaviour:
Reset (rst_n=0 at a clk edge):
- All outputs are 0.
- Arbiter is in IDLE; all counters are 0; both pending flags are cleared.
- btn synchronizer flops and the debounced level reset to 1 (released); sw synchronizer flops reset to 0.
- last_src resets to 1, so manual wins the first tie.
- Reset mid-gap or mid-debounce aborts everything; no step is issued in the reset cycle.

Input synchronization:
- btn_n and sw_in each pass through a 2-flop synchronizer.
- auto_en is used directly.

Debounce:
- Mismatch counter compares the synchronized button against the debounced level.
- On mismatch: increment; when the counter equals DEB_CYCLES-1 and the mismatch persists, flip the level and clear the counter.
- On match: clear the counter.
- A pulse shorter than DEB_CYCLES cycles is rejected.
- A debounced 1->0 transition is a press. Each press sets man_pend on the next edge. Release generates nothing.

Auto timer:
- While auto_en=1, the counter runs 0..AUTO_PERIOD-1 and wraps to 0.
- On each wrap edge, auto_pend is set. The first request occurs AUTO_PERIOD edges after auto_en rises.
- auto_en=0 clears the counter and auto_pend synchronously.

Pending rules:
- A new event for a source whose pend is already 1: drop_cnt increments, saturating at 255; pend stays 1.
- A grant clearing a pend in the same cycle a new event for that source arrives: set wins, pend stays 1, no drop.

Arbiter FSM, states IDLE and GAP:
- In IDLE with any pend=1, at the edge:
  - Select the winner. If only one source is pending, it wins. If both are pending, the source different from last_src wins (round robin).
  - Register step=1, sw_out=synchronized switches, src=winner, last_src=winner.
  - Clear the winner's pend, load the gap counter with GAP_CYCLES, and go to GAP.
- In GAP: step=0, busy=1, and the counter decrements each edge. When it reaches 1, go to IDLE, with busy=0 from that edge.
- GAP_CYCLES=0 gives back-to-back eligibility: IDLE->IDLE, busy never set, steps at most every cycle.
- Pends keep accumulating during GAP. The loser of a tie is served at the first IDLE grant after the gap.

Latency:
- Counting the first edge that samples btn_n=0 as edge 0, with the arbiter idle, step is high in the cycle following edge DEB_CYCLES+3.
- An auto wrap at edge k gives step after edge k+1.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with btn_n=0 and auto_en=1 -> step, busy, src, sw_out and drop_cnt are all 0; after release, no step for 19 edges.
- Clean press: btn_n low for 40 cycles, sw_in=2'b01, auto_en=0 -> exactly one step at edge 19 after the first low sample; sw_out=01, src=0; busy=1 for the next 4 cycles.
- Glitch rejection: btn_n low pulses of 15 cycles, then a 5-cycle bounce train -> no step; drop_cnt=0.
- Tie and round robin: auto_en=1 with a press timed so both pends are set on the same edge -> first step src=0; second step src=1 exactly 5 cycles later; third auto step src=1 at the next period.
- Drop saturation: AUTO_PERIOD=2, GAP_CYCLES=20, auto_en=1 for 1000 cycles -> drop_cnt reaches 255 and holds; steps are spaced 21 cycles apart.
- auto_en toggle: disable at counter=50, re-enable -> the next auto step comes 100 edges after re-enable plus 1; any stale auto_pend is cleared with no step.
